// File: rtl/uart_pkg.sv
// UART definitions shared by the receiver and the transmitter: the receive FSM
// encoding, the parity mode constants and the parity-bit helper.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_e;

    localparam int PARITY_NONE    = 0;
    localparam int PARITY_EVEN    = 1;
    localparam int PARITY_ODD     = 2;
    localparam int MAX_DATA_WIDTH = 9;

    // Parity bit a transmitter sends for a zero-extended data word.
    function automatic logic parity_bit(input logic [MAX_DATA_WIDTH-1:0] data, input int mode);
        return (^data) ^ (mode == PARITY_ODD);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous serial line plus the falling-edge
// detector that launches reception.
module uart_rx_sync (
    input  logic uart_clk,
    input  logic rst,
    input  logic rx_in,
    output logic rxs,
    output logic fall
);

    logic [1:0] sync;
    logic [1:0] live;
    logic       prev;

    // NOTE: non-blocking assignments make every flop sample pre-edge values, so the chain advances one stage per clock.
    always_ff @(posedge uart_clk) begin
        if (rst) begin
            sync <= 2'b11;
            live <= 2'b00;
            prev <= 1'b0;
        end else begin
            sync <= {sync[0], rx_in};
            live <= {live[0], 1'b1};
            // The reset preset of sync is not a real line level, so a line already low after reset is never an edge.
            prev <= sync[1] & live[1];
        end
    end

    assign rxs  = sync[1];
    assign fall = prev & ~sync[1];

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: mid-bit sampling FSM, parity/stop checking and a
// single-entry valid/ready output register with overrun reporting.
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int OVERSAMPLE  = 16,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1
) (
    input  logic                  uart_clk,
    input  logic                  rst,
    input  logic                  rx_in,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic                  parity_err,
    output logic                  frame_err,
    output logic                  overrun
);

    if (DATA_WIDTH < 5 || DATA_WIDTH > MAX_DATA_WIDTH) begin : g_bad_data_width
        $error("uart_rx_os: DATA_WIDTH must be in 5..9");
    end
    if (OVERSAMPLE < 4 || OVERSAMPLE > 64 || (OVERSAMPLE % 2) != 0) begin : g_bad_oversample
        $error("uart_rx_os: OVERSAMPLE must be even and in 4..64");
    end
    if (PARITY_MODE != PARITY_NONE && PARITY_MODE != PARITY_EVEN && PARITY_MODE != PARITY_ODD) begin : g_bad_parity
        $error("uart_rx_os: PARITY_MODE must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
        $error("uart_rx_os: STOP_BITS must be 1 or 2");
    end

    localparam int                TICK_W     = $clog2(OVERSAMPLE);
    localparam logic [TICK_W-1:0] TICK_MID   = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] TICK_END   = TICK_W'(OVERSAMPLE - 1);
    localparam logic [3:0]        DATA_LAST  = 4'(DATA_WIDTH - 1);
    localparam logic [3:0]        STOP_LAST  = 4'(STOP_BITS - 1);
    localparam bit                HAS_PARITY = (PARITY_MODE != PARITY_NONE);

    logic                  rxs;
    logic                  fall;
    uart_state_e           state,   state_next;
    logic [TICK_W-1:0]     tick,    tick_next;
    logic [3:0]            bit_cnt, bit_next;
    logic                  sample_data;
    logic                  sample_par;
    logic                  sample_stop;
    logic                  frame_done;
    logic [DATA_WIDTH-1:0] shift;
    logic                  par_bad;
    logic                  stop_bad;
    logic                  accept;

    uart_rx_sync u_sync (
        .uart_clk (uart_clk),
        .rst      (rst),
        .rx_in    (rx_in),
        .rxs      (rxs),
        .fall     (fall)
    );

    always_ff @(posedge uart_clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            tick    <= '0;
            bit_cnt <= '0;
        end else begin
            state   <= state_next;
            tick    <= tick_next;
            bit_cnt <= bit_next;
        end
    end

    // Tick restarts at 0 after every sample, so each later sample lands one bit period on.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves one unassigned and infers a latch.
        state_next  = state;
        tick_next   = tick + 1'b1;
        bit_next    = bit_cnt;
        sample_data = 1'b0;
        sample_par  = 1'b0;
        sample_stop = 1'b0;
        frame_done  = 1'b0;
        case (state)
            ST_IDLE: begin
                tick_next = '0;
                bit_next  = '0;
                if (fall) state_next = ST_START;
            end
            ST_START: begin
                if (tick == TICK_MID) begin
                    tick_next  = '0;
                    state_next = rxs ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (tick == TICK_END) begin
                    sample_data = 1'b1;
                    tick_next   = '0;
                    if (bit_cnt == DATA_LAST) begin
                        bit_next   = '0;
                        state_next = HAS_PARITY ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_next = bit_cnt + 4'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (tick == TICK_END) begin
                    sample_par = 1'b1;
                    tick_next  = '0;
                    state_next = ST_STOP;
                end
            end
            ST_STOP: begin
                if (tick == TICK_END) begin
                    sample_stop = 1'b1;
                    tick_next   = '0;
                    if (bit_cnt == STOP_LAST) begin
                        frame_done = 1'b1;
                        state_next = ST_IDLE;
                    end else begin
                        bit_next = bit_cnt + 4'd1;
                    end
                end
            end
            default: begin
                tick_next  = '0;
                bit_next   = '0;
                state_next = ST_IDLE;
            end
        endcase
    end

    // NOTE: the shift register has no reset; it is always fully refilled before its contents are used.
    always_ff @(posedge uart_clk) begin
        if (sample_data) shift <= {rxs, shift[DATA_WIDTH-1:1]};
    end

    always_ff @(posedge uart_clk) begin
        if (rst) begin
            par_bad  <= 1'b0;
            stop_bad <= 1'b0;
        end else begin
            if (state == ST_IDLE && fall) begin
                par_bad  <= 1'b0;
                stop_bad <= 1'b0;
            end
            if (sample_par) par_bad <= rxs ^ parity_bit(MAX_DATA_WIDTH'(shift), PARITY_MODE);
            if (sample_stop && !rxs) stop_bad <= 1'b1;
        end
    end

    assign accept = rx_valid & rx_ready;

    // A completing frame is taken only if the register is empty or being emptied this cycle.
    always_ff @(posedge uart_clk) begin
        if (rst) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else if (frame_done && (!rx_valid || accept)) begin
            rx_data    <= shift;
            rx_valid   <= 1'b1;
            parity_err <= par_bad;
            frame_err  <= stop_bad | ~rxs;
            overrun    <= 1'b0;
        end else if (frame_done) begin
            overrun <= 1'b1;
        end else if (accept) begin
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_os.sv
// Scoreboard bench for uart_rx_os: instance A (8 data bits, even parity, 1 stop,
// x16) and instance B (8 data bits, no parity, 2 stops, x8).
module tb_uart_rx_os;

    localparam int OS_A     = 16;
    localparam int OS_B     = 8;
    localparam int N_A      = 1 + 8 + 1 + 1;
    localparam int N_B      = 1 + 8 + 0 + 2;
    localparam int LAT_A    = OS_A / 2 + (N_A - 1) * OS_A + 1;
    localparam int LAT_B    = OS_B / 2 + (N_B - 1) * OS_B + 1;
    localparam int SYNC_DLY = 2;

    typedef struct {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
        logic       ovr;
        int         rise;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_a = 1'b1, rx_b = 1'b1;
    logic       ready_a = 1'b1, ready_b = 1'b1;
    logic [7:0] data_a, data_b;
    logic       valid_a, valid_b, perr_a, perr_b, ferr_a, ferr_b, ovr_a, ovr_b;
    logic       valid_a_q = 1'b0, valid_b_q = 1'b0;
    int         edge_cnt = 0;
    int         checks = 0;
    int         failures = 0;
    exp_t       qa[$];
    exp_t       qb[$];
    exp_t       ea, eb;

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    uart_rx_os #(.DATA_WIDTH(8), .OVERSAMPLE(OS_A), .PARITY_MODE(1), .STOP_BITS(1)) dut_a (
        .uart_clk (clk),     .rst        (rst),    .rx_in     (rx_a),
        .rx_data  (data_a),  .rx_valid   (valid_a), .rx_ready (ready_a),
        .parity_err (perr_a), .frame_err (ferr_a), .overrun   (ovr_a)
    );

    uart_rx_os #(.DATA_WIDTH(8), .OVERSAMPLE(OS_B), .PARITY_MODE(0), .STOP_BITS(2)) dut_b (
        .uart_clk (clk),     .rst        (rst),    .rx_in     (rx_b),
        .rx_data  (data_b),  .rx_valid   (valid_b), .rx_ready (ready_b),
        .parity_err (perr_b), .frame_err (ferr_b), .overrun   (ovr_b)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, got, exp, edge_cnt);
        end
    endtask

    // Builds the expected word from the frame's bits, queues it, then drives the line.
    // tail is {stop, parity} for A and {stop2, stop1} for B.
    task automatic send_frame(input bit to_b, input logic [7:0] d, input logic [1:0] tail,
                              input bit deliver, input bit ovr, input bit timed);
        logic [10:0] bits;
        exp_t        e;
        int          os;
        os     = to_b ? OS_B : OS_A;
        bits   = {tail, d, 1'b0};
        e.data = d;
        e.ovr  = ovr;
        if (to_b) begin
            e.perr = 1'b0;
            e.ferr = !(tail[0] && tail[1]);
            e.rise = timed ? edge_cnt + SYNC_DLY + LAT_B : 0;
            if (deliver) qb.push_back(e);
        end else begin
            e.perr = (tail[0] != ^d);
            e.ferr = !tail[1];
            e.rise = timed ? edge_cnt + SYNC_DLY + LAT_A : 0;
            if (deliver) qa.push_back(e);
        end
        for (int i = 0; i < 11; i++) begin
            if (to_b) rx_b = bits[i]; else rx_a = bits[i];
            repeat (os) @(negedge clk);
        end
        if (to_b) rx_b = 1'b1; else rx_a = 1'b1;
    endtask

    function automatic logic [1:0] good_a(input logic [7:0] d);
        return {1'b1, ^d};
    endfunction

    task automatic check_reset_outputs();
        check("reset_out_a", 32'({data_a, valid_a, perr_a, ferr_a, ovr_a}), 32'd0);
        check("reset_out_b", 32'({data_b, valid_b, perr_b, ferr_b, ovr_b}), 32'd0);
    endtask

    always begin
        @(negedge clk);
        #2;
        if (!rst) begin
            if (valid_a && !valid_a_q && qa.size() > 0 && qa[0].rise != 0)
                check("rise_time_a", 32'(edge_cnt), 32'(qa[0].rise));
            if (valid_a && ready_a) begin
                if (qa.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL spurious_word_a: got data 0x%0h, expected no word", data_a);
                end else begin
                    ea = qa.pop_front();
                    check("data_a", 32'(data_a), 32'(ea.data));
                    check("flags_a", 32'({perr_a, ferr_a, ovr_a}), 32'({ea.perr, ea.ferr, ea.ovr}));
                end
            end
        end
        valid_a_q = valid_a;
    end

    always begin
        @(negedge clk);
        #2;
        if (!rst) begin
            if (valid_b && !valid_b_q && qb.size() > 0 && qb[0].rise != 0)
                check("rise_time_b", 32'(edge_cnt), 32'(qb[0].rise));
            if (valid_b && ready_b) begin
                if (qb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL spurious_word_b: got data 0x%0h, expected no word", data_b);
                end else begin
                    eb = qb.pop_front();
                    check("data_b", 32'(data_b), 32'(eb.data));
                    check("flags_b", 32'({perr_b, ferr_b, ovr_b}), 32'({eb.perr, eb.ferr, eb.ovr}));
                end
            end
        end
        valid_b_q = valid_b;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no end of test, expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0]  d;
        logic [1:0]  tail;
        logic [10:0] broken;
        int          kind;

        repeat (4) @(negedge clk);
        #3;
        check_reset_outputs();
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        // Clean frame with exact latency.
        send_frame(0, 8'hA5, good_a(8'hA5), 1, 0, 1);
        repeat (10) @(negedge clk);

        // Short low glitch is a false start; the following frame must still decode.
        rx_a = 1'b0;
        repeat (4) @(negedge clk);
        rx_a = 1'b1;
        repeat (30) @(negedge clk);
        send_frame(0, 8'h3C, good_a(8'h3C), 1, 0, 1);
        repeat (10) @(negedge clk);

        // Parity error, then framing error; both words still delivered.
        send_frame(0, 8'h3C, {1'b1, ~^8'h3C}, 1, 0, 1);
        send_frame(0, 8'h3C, {1'b0, ^8'h3C}, 1, 0, 1);
        repeat (5) @(negedge clk);

        // Overrun: second word is dropped while the first is held.
        ready_a = 1'b0;
        send_frame(0, 8'h11, good_a(8'h11), 1, 1, 1);
        send_frame(0, 8'h22, good_a(8'h22), 0, 0, 0);
        repeat (5) @(negedge clk);
        #3;
        check("overrun_hold_a", 32'({valid_a, data_a, ovr_a}), 32'({1'b1, 8'h11, 1'b1}));
        @(negedge clk);
        ready_a = 1'b1;
        @(negedge clk);
        ready_a = 1'b0;
        #3;
        check("valid_clear_a", 32'(valid_a), 32'd0);

        // Accept in the completion cycle: new word loads, valid stays high.
        @(negedge clk);
        send_frame(0, 8'h33, good_a(8'h33), 1, 0, 1);
        fork
            send_frame(0, 8'h44, good_a(8'h44), 1, 0, 0);
            begin
                repeat (SYNC_DLY + LAT_A - 1) @(negedge clk);
                ready_a = 1'b1;
                @(negedge clk);
                ready_a = 1'b0;
            end
        join
        #3;
        check("coincident_load_a", 32'({valid_a, data_a, ovr_a}), 32'({1'b1, 8'h44, 1'b0}));
        @(negedge clk);
        ready_a = 1'b1;
        @(negedge clk);
        ready_a = 1'b1;
        repeat (5) @(negedge clk);

        // Reset mid-frame with a held word, then a held-low line, then a clean frame.
        ready_a = 1'b0;
        send_frame(0, 8'h77, good_a(8'h77), 1, 0, 1);
        repeat (3) @(negedge clk);
        #3;
        check("pre_reset_valid_a", 32'({valid_a, data_a}), 32'({1'b1, 8'h77}));
        @(negedge clk);
        broken = {good_a(8'h12), 8'h12, 1'b0};
        for (int i = 0; i < 4; i++) begin
            rx_a = broken[i];
            repeat (OS_A) @(negedge clk);
        end
        rx_a = broken[4];
        repeat (OS_A / 2) @(negedge clk);
        rst = 1'b1;
        qa.delete();
        qb.delete();
        repeat (3) begin
            @(negedge clk);
            #3;
            check_reset_outputs();
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (60) @(negedge clk);
        rx_a = 1'b1;
        repeat (30) @(negedge clk);
        ready_a = 1'b1;
        send_frame(0, 8'h5A, good_a(8'h5A), 1, 0, 1);
        repeat (5) @(negedge clk);

        // Randomised frames on A with occasional parity or stop corruption.
        for (int n = 0; n < 12; n++) begin
            d    = 8'($urandom);
            kind = int'($urandom_range(0, 9));
            tail = good_a(d);
            if (kind == 8) tail[0] = ~tail[0];
            if (kind == 9) tail[1] = 1'b0;
            send_frame(0, d, tail, 1, 0, 1);
            repeat (int'($urandom_range(0, 12)) + (tail[1] ? 0 : 2)) @(negedge clk);
        end

        // Instance B: no parity, two stop bits, x8 oversampling.
        send_frame(1, 8'hA5, 2'b11, 1, 0, 1);
        repeat (10) @(negedge clk);
        for (int n = 0; n < 8; n++) begin
            d    = 8'($urandom);
            kind = int'($urandom_range(0, 5));
            tail = (kind == 4) ? 2'b10 : (kind == 5) ? 2'b01 : 2'b11;
            send_frame(1, d, tail, 1, 0, 1);
            repeat (int'($urandom_range(0, 6)) + (tail[1] ? 0 : 2)) @(negedge clk);
        end

        repeat (40) @(negedge clk);
        #3;
        check("pending_a", 32'(qa.size()), 32'd0);
        check("pending_b", 32'(qb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx_os.md
UART_RX_OS -- requirements
Module: uart_rx_os

Interface
REQ-001 The module SHALL expose parameter DATA_WIDTH, default 8, meaning data bits per frame, legal range 5..9.
REQ-002 The module SHALL expose parameter OVERSAMPLE, default 16, meaning uart_clk cycles per bit, even, legal range 4..64.
REQ-003 The module SHALL expose parameter PARITY_MODE, default 0, meaning 0=none, 1=even, 2=odd.
REQ-004 The module SHALL expose parameter STOP_BITS, default 1, meaning stop bits checked per frame, 1 or 2.
REQ-005 The module SHALL have port uart_clk, input, 1 bit: single clock at OVERSAMPLE x baud.
REQ-006 The module SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 The module SHALL have port rx_in, input, 1 bit: asynchronous serial line, idle high, LSB first.
REQ-008 The module SHALL have port rx_data, output, DATA_WIDTH bits: received word, valid while rx_valid=1.
REQ-009 The module SHALL have ports rx_valid (output, 1 bit) and rx_ready (input, 1 bit): valid/ready output handshake.
REQ-010 The module SHALL have ports parity_err, frame_err and overrun, each output, 1 bit: status qualified by rx_valid.

Function
REQ-011 rx_in SHALL pass through a 2-flop synchroniser; all logic uses the synchronised line (rxs), which is rx_in delayed 2 cycles.
REQ-012 FSM states SHALL be IDLE, START, DATA, PARITY, STOP; one tick counter (0..OVERSAMPLE-1) and one bit counter.
REQ-013 IDLE->START SHALL occur only on a 1->0 edge of rxs; t0 = first cycle rxs reads 0; a line held low (break) never restarts reception.
REQ-014 In START, rxs SHALL be sampled at t0+OVERSAMPLE/2; if 1 it is a false start -> IDLE, with no output or flag change.
REQ-015 Data bit i (0..DATA_WIDTH-1) SHALL be sampled at t0+OVERSAMPLE/2+(1+i)*OVERSAMPLE and stored to bit i.
REQ-016 PARITY state SHALL exist only when PARITY_MODE!=0; its sample is compared with XOR of the data (even) or its inverse (odd); a mismatch sets parity_err.
REQ-017 Each of STOP_BITS stop samples SHALL be checked; any 0 sets frame_err; after the last stop sample the FSM returns to IDLE on the next cycle.
REQ-018 With N = 1+DATA_WIDTH+(PARITY_MODE!=0)+STOP_BITS, rx_valid SHALL rise at t0+OVERSAMPLE/2+(N-1)*OVERSAMPLE+1.
REQ-019 The output register SHALL hold rx_data and all flags stable while rx_valid=1 and rx_ready=0; rx_valid clears the cycle after rx_valid&rx_ready.
REQ-020 A frame completing while rx_valid=1 and rx_ready=0 SHALL be discarded; overrun sets and stays set until that word is accepted.
REQ-021 A frame completing in the same cycle as an accepting handshake SHALL load the new word with rx_valid remaining 1 and overrun=0.
REQ-022 Frames with parity_err or frame_err SHALL still be delivered, with the flags attached.
REQ-023 Reception SHALL be independent of rx_ready: the FSM never stalls.

Reset
REQ-024 While rst=1, the FSM SHALL be in IDLE, the counters at 0, and the synchroniser flops at 1.
REQ-025 While rst=1, rx_data, rx_valid, parity_err, frame_err and overrun SHALL be 0.
REQ-026 Reset asserted mid-frame SHALL abandon the frame; after release, a new falling edge is required.

Structure
REQ-027 Package uart_pkg SHALL hold the FSM state encoding and the PARITY_NONE, PARITY_EVEN and PARITY_ODD constants, shared with the transmitter.
REQ-028 Sub-module uart_rx_sync SHALL implement the 2-flop synchroniser and falling-edge detect; all other logic SHALL stay in uart_rx_os.
REQ-029 Illegal parameter values SHALL be rejected at elaboration.

Verification (DATA_WIDTH=8, OVERSAMPLE=16, PARITY_MODE=1, STOP_BITS=1 unless stated)
REQ-030 Frame 0xA5 with parity bit 0, rx_ready=1 -> rx_data=0xA5 with all flags 0, and rx_valid high exactly at t0+169 for one cycle.
REQ-031 rx_in low for 4 cycles, then high -> no rx_valid; the next valid frame 0x3C is received correctly.
REQ-032 Frame 0x3C with parity bit 1 -> parity_err=1; with stop bit 0 -> frame_err=1; rx_data=0x3C in both cases.
REQ-033 Back-to-back frames 0x11 and 0x22 with rx_ready=0 -> rx_data stays 0x11 with overrun=1; after one rx_ready pulse rx_valid=0; an accept coincident with completion delivers the new word per REQ-021.
REQ-034 rst pulsed at the fourth data bit of a frame, followed by a held-low line, then a full 0x5A frame -> outputs are 0 during reset, no word is produced from the broken frame, and 0x5A is received cleanly.
REQ-035 Repeat the REQ-030 scenario with PARITY_MODE=0, STOP_BITS=2 and OVERSAMPLE=8 -> rx_valid at t0+4+10*8+1=t0+85.
